// File: rtl/circuit2_result_fifo_if.sv
// Handshake/result bus between the circuit2 datapath, its result FIFO and the consumer.
// master = upstream/consumer side, slave = the FIFO itself.
interface circuit2_result_fifo_if #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic [DATAWIDTH-1:0] in_z;
  logic [DATAWIDTH-1:0] in_x;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_z;
  logic [DATAWIDTH-1:0] out_x;
  logic [CW-1:0]        count;
  logic [DATAWIDTH-1:0] z_sum;
  logic                 overflow;

  modport master (
    output in_valid, in_z, in_x, out_ready,
    input  in_ready, out_valid, out_z, out_x, count, z_sum, overflow
  );

  modport slave (
    input  in_valid, in_z, in_x, out_ready,
    output in_ready, out_valid, out_z, out_x, count, z_sum, overflow
  );
endinterface

// File: rtl/circuit2_result_fifo.sv
// Result FIFO for the circuit2 datapath: buffers {z,x} pairs, presents the head
// show-ahead, tracks occupancy, accumulates popped z values and flags pushes into
// a full FIFO. Flow-control flags decode from registered occupancy only, so there
// is no combinational path from out_ready to in_ready or from in_* to out_*.
module circuit2_result_fifo #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  circuit2_result_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT_C  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_CNT_C = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO_C  = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE_C   = AW'(1'b1);

  logic [DATAWIDTH-1:0] mem_z_r [DEPTH];
  logic [DATAWIDTH-1:0] mem_x_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [DATAWIDTH-1:0] z_sum_r;
  logic                 overflow_r;

  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 push_s;
  logic                 pop_s;
  logic [DATAWIDTH-1:0] head_z_s;
  logic [DATAWIDTH-1:0] head_x_s;

  // Decode handshake qualifiers and the head entry from registered state.
  always_comb begin
    in_ready_s  = (count_r != FULL_CNT_C);
    out_valid_s = (count_r != EMPTY_CNT_C);
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = out_valid_s && bus.out_ready;
    head_z_s    = mem_z_r[rd_ptr_r];
    head_x_s    = mem_x_r[rd_ptr_r];
  end

  // Write an accepted pair at the write pointer; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_z_r[wr_ptr_r] <= bus.in_z;
      mem_x_r[wr_ptr_r] <= bus.in_x;
    end
  end

  // Pointers, occupancy, popped-z accumulator and sticky overflow; reset wins over traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= PTR_ZERO_C;
      rd_ptr_r   <= PTR_ZERO_C;
      count_r    <= EMPTY_CNT_C;
      z_sum_r    <= {DATAWIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
        z_sum_r  <= z_sum_r + head_z_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
      // A push attempt against a full FIFO is recorded even if a pop frees a slot this cycle.
      if (bus.in_valid && !in_ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_z     = head_z_s;
  assign bus.out_x     = head_x_s;
  assign bus.count     = count_r;
  assign bus.z_sum     = z_sum_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_circuit2_result_fifo.sv
// Directed self-checking bench for circuit2_result_fifo (DATAWIDTH=32, DEPTH=4).
module tb_circuit2_result_fifo;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  circuit2_result_fifo_if #(.DATAWIDTH(32), .DEPTH(4)) fifo_bus ();

  circuit2_result_fifo #(.DATAWIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fifo_bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] z, input logic [31:0] x);
    fifo_bus.in_valid = 1'b1;
    fifo_bus.in_z     = z;
    fifo_bus.in_x     = x;
    step();
    fifo_bus.in_valid = 1'b0;
  endtask

  // Check the head, then pop it (out_ready held by caller).
  task automatic pop_check(input string tag, input logic [31:0] z, input logic [31:0] x);
    check({tag, "_valid"}, {31'd0, fifo_bus.out_valid}, 32'd1);
    check({tag, "_z"}, fifo_bus.out_z, z);
    check({tag, "_x"}, fifo_bus.out_x, x);
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst               = 1'b1;
    fifo_bus.in_valid  = 1'b0;
    fifo_bus.in_z      = 32'd0;
    fifo_bus.in_x      = 32'd0;
    fifo_bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count",    {28'd0, fifo_bus.count}, 32'd0);
    check("rst_out_valid", {31'd0, fifo_bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, fifo_bus.in_ready}, 32'd1);
    check("rst_z_sum",    fifo_bus.z_sum, 32'd0);
    check("rst_overflow", {31'd0, fifo_bus.overflow}, 32'd0);

    // Three pushes, no consumer; first push visible after one edge
    push(32'd5, 32'd7);
    check("lat_out_valid", {31'd0, fifo_bus.out_valid}, 32'd1);
    check("lat_count",     {28'd0, fifo_bus.count}, 32'd1);
    push(32'd10, 32'd3);
    push(32'd1, 32'd0);
    check("p3_count",    {28'd0, fifo_bus.count}, 32'd3);
    check("p3_out_z",    fifo_bus.out_z, 32'd5);
    check("p3_out_x",    fifo_bus.out_x, 32'd7);
    check("p3_in_ready", {31'd0, fifo_bus.in_ready}, 32'd1);

    // Drain in order
    fifo_bus.out_ready = 1'b1;
    pop_check("d0", 32'd5, 32'd7);
    pop_check("d1", 32'd10, 32'd3);
    pop_check("d2", 32'd1, 32'd0);
    check("d_count",     {28'd0, fifo_bus.count}, 32'd0);
    check("d_out_valid", {31'd0, fifo_bus.out_valid}, 32'd0);
    check("d_z_sum",     fifo_bus.z_sum, 32'd16);
    // out_ready while empty changes nothing
    step();
    check("empty_pop_count", {28'd0, fifo_bus.count}, 32'd0);
    check("empty_pop_z_sum", fifo_bus.z_sum, 32'd16);
    fifo_bus.out_ready = 1'b0;

    // Fill, then push into full FIFO
    push(32'd1, 32'd11);
    push(32'd2, 32'd12);
    push(32'd3, 32'd13);
    push(32'd4, 32'd14);
    check("full_in_ready", {31'd0, fifo_bus.in_ready}, 32'd0);
    check("full_count",    {28'd0, fifo_bus.count}, 32'd4);
    check("full_ovf_pre",  {31'd0, fifo_bus.overflow}, 32'd0);
    push(32'd99, 32'd99);
    check("ovf_count", {28'd0, fifo_bus.count}, 32'd4);
    check("ovf_flag",  {31'd0, fifo_bus.overflow}, 32'd1);
    fifo_bus.out_ready = 1'b1;
    pop_check("of0", 32'd1, 32'd11);
    pop_check("of1", 32'd2, 32'd12);
    pop_check("of2", 32'd3, 32'd13);
    pop_check("of3", 32'd4, 32'd14);
    check("of_count",     {28'd0, fifo_bus.count}, 32'd0);
    check("of_out_valid", {31'd0, fifo_bus.out_valid}, 32'd0);
    check("of_sticky",    {31'd0, fifo_bus.overflow}, 32'd1);
    check("of_z_sum",     fifo_bus.z_sum, 32'd26);
    fifo_bus.out_ready = 1'b0;

    // Simultaneous push/pop at count=2, 10 times so pointers wrap
    push(32'd21, 32'd8);
    push(32'd22, 32'd8);
    check("sim_start_count", {28'd0, fifo_bus.count}, 32'd2);
    fifo_bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fifo_bus.in_valid = 1'b1;
      fifo_bus.in_z     = 32'd30 + i;
      fifo_bus.in_x     = 32'd8;
      if (i == 0)      check("sim_head", fifo_bus.out_z, 32'd21);
      else if (i == 1) check("sim_head", fifo_bus.out_z, 32'd22);
      else             check("sim_head", fifo_bus.out_z, 32'd28 + i);
      step();
      check("sim_count", {28'd0, fifo_bus.count}, 32'd2);
    end
    fifo_bus.in_valid = 1'b0;
    pop_check("sim_tail0", 32'd38, 32'd8);
    pop_check("sim_tail1", 32'd39, 32'd8);
    check("sim_end_count", {28'd0, fifo_bus.count}, 32'd0);
    check("sim_z_sum",     fifo_bus.z_sum, 32'd414);
    fifo_bus.out_ready = 1'b0;

    // z_sum wrap-around from zero
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wrap_rst_z_sum", fifo_bus.z_sum, 32'd0);
    check("wrap_rst_ovf",   {31'd0, fifo_bus.overflow}, 32'd0);
    push(32'hFFFF_FFFF, 32'd0);
    push(32'h0000_0002, 32'd0);
    fifo_bus.out_ready = 1'b1;
    pop_check("wrap0", 32'hFFFF_FFFF, 32'd0);
    check("wrap_mid_z_sum", fifo_bus.z_sum, 32'hFFFF_FFFF);
    pop_check("wrap1", 32'h0000_0002, 32'd0);
    check("wrap_z_sum", fifo_bus.z_sum, 32'h0000_0001);
    fifo_bus.out_ready = 1'b0;

    // Reset mid-operation with count=3, overflow=1, in_valid=1
    push(32'd1, 32'd1);
    push(32'd2, 32'd2);
    push(32'd3, 32'd3);
    push(32'd4, 32'd4);
    push(32'd5, 32'd5);
    fifo_bus.out_ready = 1'b1;
    step();
    fifo_bus.out_ready = 1'b0;
    check("pre_rst_count", {28'd0, fifo_bus.count}, 32'd3);
    check("pre_rst_ovf",   {31'd0, fifo_bus.overflow}, 32'd1);
    rst = 1'b1;
    fifo_bus.in_valid = 1'b1;
    fifo_bus.in_z     = 32'd77;
    fifo_bus.in_x     = 32'd77;
    step();
    rst = 1'b0;
    fifo_bus.in_valid = 1'b0;
    check("mr_count",     {28'd0, fifo_bus.count}, 32'd0);
    check("mr_z_sum",     fifo_bus.z_sum, 32'd0);
    check("mr_overflow",  {31'd0, fifo_bus.overflow}, 32'd0);
    check("mr_out_valid", {31'd0, fifo_bus.out_valid}, 32'd0);
    check("mr_in_ready",  {31'd0, fifo_bus.in_ready}, 32'd1);
    push(32'd42, 32'd43);
    check("mr_head_z", fifo_bus.out_z, 32'd42);
    check("mr_head_x", fifo_bus.out_x, 32'd43);
    check("mr_count1", {28'd0, fifo_bus.count}, 32'd1);

    // Full with simultaneous pop: push rejected, overflow set, pop completes
    push(32'd50, 32'd60);
    push(32'd51, 32'd61);
    push(32'd52, 32'd62);
    fifo_bus.in_valid  = 1'b1;
    fifo_bus.in_z      = 32'd99;
    fifo_bus.in_x      = 32'd99;
    fifo_bus.out_ready = 1'b1;
    step();
    fifo_bus.in_valid = 1'b0;
    check("fp_count",    {28'd0, fifo_bus.count}, 32'd3);
    check("fp_overflow", {31'd0, fifo_bus.overflow}, 32'd1);
    pop_check("fp0", 32'd50, 32'd60);
    pop_check("fp1", 32'd51, 32'd61);
    pop_check("fp2", 32'd52, 32'd62);
    check("fp_end_count", {28'd0, fifo_bus.count}, 32'd0);
    check("fp_out_valid", {31'd0, fifo_bus.out_valid}, 32'd0);
    fifo_bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
